bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares one port of bram_synch_dual_port among NUM_REQ requesters.
//  Each requester issues single-word read or write transactions with a req/gnt handshake.
//  The arbiter muxes the winner onto the BRAM port and routes read data back with a per-requester valid pulse.
//  It sits between client logic (DMA, CPU bus bridge, video fetch) and the BRAM port A or B signals.
// PARAMETERS
//  ADDR_WIDTH  3  BRAM address width; must match the attached BRAM.
//  DATA_WIDTH  8  BRAM data width; must match the attached BRAM.
//  NUM_REQ     4  number of requesters, 2..8.
// PORTS
//  clk        in   1                     single clock, rising edge.
//  reset      in   1                     asynchronous, active-high.
//  req        in   NUM_REQ               request per requester.
//  we         in   NUM_REQ               1 = write, 0 = read; per requester.
//  addr       in   NUM_REQ*ADDR_WIDTH    flattened; slice i = requester i.
//  din        in   NUM_REQ*DATA_WIDTH    flattened write data.
//  lock       in   NUM_REQ               burst lock request; used only with ARB_LOCK_EN.
//  gnt        out  NUM_REQ               one-hot (or zero) grant, combinational.
//  rvalid     out  NUM_REQ               registered one-cycle read-data-valid pulse.
//  rdata      out  DATA_WIDTH            read data = mem_dout, broadcast to all requesters.
//  mem_we     out  1                     to BRAM we_x.
//  mem_addr   out  ADDR_WIDTH            to BRAM addr_x.
//  mem_din    out  DATA_WIDTH            to BRAM din_x.
//  mem_dout   in   DATA_WIDTH            from BRAM dout_x.
// BEHAVIOUR
//  - Handshake: a requester raises req[i] with we/addr/din stable and holds them until a rising edge where gnt[i]=1.
//  - That edge is the transfer; the requester may change or drop req afterwards. Dropping req before a grant is legal.
//  - Grant: at most one gnt bit per cycle; gnt[i]=1 only if req[i]=1. gnt=0 whenever req=0.
//  - Round-robin: state ptr (clog2 NUM_REQ bits). Search order is ptr, ptr+1, .., wrapping modulo NUM_REQ.
//  - After a transfer by requester i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
//  - Fairness: with all req held high, grant order is 0,1,..,NUM_REQ-1,0,..
//  - A lone requester is granted every cycle: back-to-back at full rate.
//  - BRAM mux: mem_addr/mem_din are taken from the granted slice, else from slice 0.
//  - mem_we = |(gnt & we): no BRAM write without a grant.
//  - Read latency: a read granted at edge N gives rvalid[i]=1 for the cycle after N.
//  - rdata is valid only while rvalid[i]=1. A write grant produces no rvalid.
//  - Read-during-write: the BRAM returns old data.
//    Other-port collisions at the same address are the system's responsibility.
//  - Reset (async, any time): ptr=0, rvalid=0, FSM=ARB.
//    While reset=1, gnt=0 and mem_we=0 (forced), so no BRAM write occurs.
//    An access in flight is dropped: its rvalid is never issued.
//  - FSM (only with ARB_LOCK_EN): ARB, LOCKED(owner).
//    ARB -> LOCKED when requester i transfers with lock[i]=1; owner<=i; ptr unchanged.
//    LOCKED: only owner may be granted; other req wait.
//    LOCKED -> ARB on an owner transfer with lock=0 (then ptr<=owner+1), or when req[owner]=0 (ptr<=owner+1).
// CONFIGURATION
//  ARB_LOCK_EN defined: lock input honoured; LOCKED state gives an owner exclusive back-to-back access (bursts).
//  ARB_LOCK_EN undefined: lock input ignored; FSM stays in ARB; pure round-robin, one transfer per grant.
// TESTING
//  1. Reset mid-read: grant read at edge N, assert reset before N+1 -> rvalid stays 0, gnt=0, mem_we=0, ptr=0.
//  2. Single requester: req=4'b0100, we=0, addr=5, mem[5]=8'hA5 -> gnt=4'b0100 each cycle.
//     The cycle after, rvalid=4'b0100 and rdata=8'hA5.
//  3. All req=4'hF held 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; exactly one gnt bit per cycle.
//  4. Write then read: req1 writes addr=3 din=8'h5C, then req2 reads addr=3 -> rvalid[2]=1, rdata=8'h5C.
//     Without a grant, mem_we is never 1.
//  5. Wrap/skip: ptr=3, req=4'b0011 -> gnt=4'b0001, then 4'b0010; ptr becomes 2.
//  6. ARB_LOCK_EN: req=4'hF, lock[1]=1 for 3 transfers then 0 -> grants 0,1,1,1,1,2,3.
//     Without the macro -> 0,1,2,3,0,1,2.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signal bundle for bram_port_arbiter.
// slave = arbiter view; master = clients plus the attached BRAM port.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] din;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_din;
  logic [DATA_WIDTH-1:0]         mem_dout;

  modport slave (
    input  req, we, addr, din, lock, mem_dout,
    output gnt, rvalid, rdata, mem_we, mem_addr, mem_din
  );

  modport master (
    output req, we, addr, din, lock, mem_dout,
    input  gnt, rvalid, rdata, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous BRAM port among NUM_REQ requesters.
// Define ARB_LOCK_EN to honour lock[] and allow an owner exclusive burst access.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input logic               clk,
  input logic               reset,
  bram_port_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             state, state_nx;
  logic [PW-1:0]      ptr, ptr_nx, owner, owner_nx;
  logic [PW-1:0]      win, sel;
  logic               any, xfer;
  int                 idx;
  logic [NUM_REQ-1:0] gnt_w;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && bus.req[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    case (state)
      ARB: begin
        if (xfer) begin
          if (LOCK_EN && bus.lock[win]) begin
            state_nx = LOCKED;
            owner_nx = win;
          end else begin
            ptr_nx = nxt(win);
          end
        end
      end
      LOCKED: begin
        // Owner releases either by dropping req or by a final unlocked transfer
        if (!bus.req[owner] || !bus.lock[owner]) begin
          state_nx = ARB;
          ptr_nx   = nxt(owner);
        end
      end
      default: state_nx = ARB;
    endcase
  end

  // Grant is forced off during reset so the BRAM never sees a write then
  always_comb begin
    gnt_w = '0;
    if (!reset) begin
      if (state == LOCKED) begin
        if (bus.req[owner]) gnt_w[owner] = 1'b1;
      end else if (any) begin
        gnt_w[win] = 1'b1;
      end
    end
  end

  assign xfer = |gnt_w;
  assign sel  = xfer ? ((state == LOCKED) ? owner : win) : '0;

  assign bus.gnt      = gnt_w;
  assign bus.mem_we   = |(gnt_w & bus.we);
  assign bus.mem_addr = bus.addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_din  = bus.din[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.rdata    = bus.mem_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.rvalid <= '0;
    else       bus.rvalid <= gnt_w & ~bus.we;
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural synchronous BRAM model.
// Honours ARB_LOCK_EN for the burst-lock grant order.
module tb_bram_port_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // BRAM: registered read returning old data on read-during-write, plus a backdoor loader
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_dout_q = '0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    mem_dout_q <= mem[bus.mem_addr];
  end
  assign bus.mem_dout = mem_dout_q;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR-1:0]    we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] din;
    logic [NR-1:0]    gnt;
    logic             mem_we;
    logic [AW-1:0]    maddr;
    logic [DW-1:0]    mdin;
    logic [NR-1:0]    rvalid;
    logic [DW-1:0]    rdata;
  } vec_t;

  vec_t vt [10];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] w, input logic [11:0] a,
                              input logic [31:0] d, input logic [3:0] g, input logic mw,
                              input logic [2:0] ma, input logic [7:0] md,
                              input logic [3:0] rv, input logic [7:0] rd);
    vec_t v;
    v.req = rq; v.we = w; v.addr = a; v.din = d; v.gnt = g; v.mem_we = mw;
    v.maddr = ma; v.mdin = md; v.rvalid = rv; v.rdata = rd;
    return v;
  endfunction

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  int exp_ord [7];
  int n1;
  logic [NR-1:0] g;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // req, we, addr, din, gnt, mem_we, mem_addr, mem_din, rvalid(next), rdata(next)
    vt[0] = mk(4'b0100, 4'b0000, 12'h140, 32'h0,        4'b0100, 1'b0, 3'd5, 8'h00, 4'b0100, 8'hA5);
    vt[1] = vt[0];
    vt[2] = vt[0];
    vt[3] = mk(4'b0011, 4'b0000, 12'h011, 32'h0,        4'b0001, 1'b0, 3'd1, 8'h00, 4'b0001, 8'h11);
    vt[4] = mk(4'b0011, 4'b0000, 12'h011, 32'h0,        4'b0010, 1'b0, 3'd2, 8'h00, 4'b0010, 8'h22);
    vt[5] = mk(4'b0010, 4'b0010, 12'h018, 32'h00005C00, 4'b0010, 1'b1, 3'd3, 8'h5C, 4'b0000, 8'h00);
    vt[6] = mk(4'b0100, 4'b0000, 12'h0C0, 32'h0,        4'b0100, 1'b0, 3'd3, 8'h00, 4'b0100, 8'h5C);
    vt[7] = mk(4'b0000, 4'b1111, 12'h006, 32'h00000077, 4'b0000, 1'b0, 3'd6, 8'h77, 4'b0000, 8'h00);
    vt[8] = mk(4'b1000, 4'b1000, 12'hE02, 32'h99000001, 4'b1000, 1'b1, 3'd7, 8'h99, 4'b0000, 8'h00);
    vt[9] = mk(4'b0001, 4'b0000, 12'h007, 32'h0,        4'b0001, 1'b0, 3'd7, 8'h00, 4'b0001, 8'h99);
`ifdef ARB_LOCK_EN
    exp_ord = '{0, 1, 1, 1, 1, 2, 3};
`else
    exp_ord = '{0, 1, 2, 3, 0, 1, 2};
`endif

    bus.req = 4'hF; bus.we = 4'hF; bus.addr = '0; bus.din = '0; bus.lock = '0;
    @(posedge clk); #1;
    chk("reset gnt", 32'(bus.gnt), 32'h0);
    chk("reset mem_we", 32'(bus.mem_we), 32'h0);
    chk("reset rvalid", 32'(bus.rvalid), 32'h0);
    bus.req = '0; bus.we = '0;
    bd_write(3'd5, 8'hA5);
    bd_write(3'd1, 8'h11);
    bd_write(3'd2, 8'h22);
    bd_write(3'd3, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      bus.req = vt[i].req; bus.we = vt[i].we; bus.addr = vt[i].addr; bus.din = vt[i].din;
      #1;
      chk($sformatf("v%0d gnt", i), 32'(bus.gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vt[i].mem_we));
      chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vt[i].maddr));
      chk($sformatf("v%0d mem_din", i), 32'(bus.mem_din), 32'(vt[i].mdin));
      @(posedge clk); #1;
      chk($sformatf("v%0d rvalid", i), 32'(bus.rvalid), 32'(vt[i].rvalid));
      if (vt[i].rvalid != '0)
        chk($sformatf("v%0d rdata", i), 32'(bus.rdata), 32'(vt[i].rdata));
    end

    // Reset asserted mid-cycle with writes pending; ptr is 1 here
    bus.req = 4'hF; bus.we = 4'hF; bus.addr = '0; bus.din = '0;
    #1;
    chk("pre-reset gnt", 32'(bus.gnt), 32'h2);
    chk("pre-reset mem_we", 32'(bus.mem_we), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset gnt", 32'(bus.gnt), 32'h0);
    chk("async reset mem_we", 32'(bus.mem_we), 32'h0);
    bus.we = 4'h0;
    @(posedge clk); #1;
    chk("in-reset rvalid", 32'(bus.rvalid), 32'h0);
    chk("in-reset gnt", 32'(bus.gnt), 32'h0);
    @(posedge clk); #1;
    chk("in-reset rvalid2", 32'(bus.rvalid), 32'h0);
    chk("mem[1] kept", 32'(mem[1]), 32'h11);
    reset = 1'b0;

    // Fairness from ptr=0 with all requesters reading
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d gnt", k), 32'(bus.gnt), 32'(1 << (k % NR)));
      chk($sformatf("rr%0d onehot", k), 32'($countones(bus.gnt)), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("rr%0d rvalid", k), 32'(bus.rvalid), 32'(1 << (k % NR)));
    end

    // Burst lock: lock[1] held for its first three transfers
    reset = 1'b1; #1; reset = 1'b0;
    n1 = 0;
    for (int k = 0; k < 7; k++) begin
      bus.lock = (n1 < 3) ? 4'b0010 : 4'b0000;
      #1;
      g = bus.gnt;
      chk($sformatf("lock%0d gnt", k), 32'(g), 32'(1 << exp_ord[k]));
      if (g[1]) n1++;
      @(posedge clk); #1;
    end
    bus.req = '0; bus.lock = '0;
    #1;
    chk("idle gnt", 32'(bus.gnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
